// File: rtl/scan_key_decoder_if.sv
// Key token stream between the scan-code decoder and the calculator front-end.
// The decoder (master) presents the FIFO head; the consumer (slave) pops with key_ready.
interface scan_key_decoder_if;
  logic [3:0] key_data;
  logic       key_enter;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_data, output key_enter, output key_valid, input key_ready);
  modport slave  (input key_data, input key_enter, input key_valid, output key_ready);
endinterface

// File: rtl/scan_key_decoder.sv
// PS/2 set-2 scan-code decoder: tracks E0/F0 prefixes and shift, drops break codes
// and typematic repeats, and queues 4-bit key tokens in a first-word-fall-through FIFO.
module scan_key_decoder #(
  parameter int DEPTH           = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 scan_code_in,
  input  logic                       scan_valid,
  scan_key_decoder_if.master         kif,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  input  logic                       clear_ovf
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_ENTER  = 8'h5A;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

  // Token entry: {enter, data}
  typedef struct packed {
    logic       enter;
    logic [3:0] data;
  } token_t;

  state_t     state_q, state_d;
  logic       shift_q, shift_d;
  logic [7:0] held_q, held_d;
  logic       push;
  token_t     push_tok;

  // Map a plain make code to a token; returns {hit, token}
  function automatic logic [5:0] map_make(input logic [7:0] code, input logic shift);
    logic [5:0] r;
    r = 6'b0;
    case (code)
      8'h16: r = {1'b1, 1'b0, 4'h1};
      8'h1E: r = {1'b1, 1'b0, 4'h2};
      8'h26: r = {1'b1, 1'b0, 4'h3};
      8'h25: r = {1'b1, 1'b0, 4'h4};
      8'h2E: r = {1'b1, 1'b0, (shift ? 4'hD : 4'h5)};
      8'h36: r = {1'b1, 1'b0, 4'h6};
      8'h3D: r = {1'b1, 1'b0, 4'h7};
      8'h3E: r = {1'b1, 1'b0, 4'h8};
      8'h46: r = {1'b1, 1'b0, 4'h9};
      8'h45: r = {1'b1, 1'b0, 4'h0};
      8'h4A: r = {1'b1, 1'b0, 4'hA};
      8'h4E: r = {1'b1, 1'b0, 4'hB};
      8'h5D: r = {1'b1, 1'b0, 4'hC};
      8'h66: r = {1'b1, 1'b0, 4'hE};
      8'h5A: r = {1'b1, 1'b1, 4'hF};
      default: r = 6'b0;
    endcase
    return r;
  endfunction

  // Prefix FSM next state, shift/held-key tracking and token generation
  always_comb begin
    logic [5:0] m;
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    shift_d  = shift_q;
    held_d   = held_q;
    push     = 1'b0;
    push_tok = '0;
    m        = map_make(scan_code_in, shift_q);
    if (scan_valid) begin
      if (scan_code_in == CODE_EXT) begin
        state_d = ST_EXT;
      end else if (scan_code_in == CODE_BRK) begin
        state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      end else begin
        state_d = ST_IDLE;
        case (state_q)
          ST_IDLE: begin
            if (scan_code_in == CODE_LSHIFT || scan_code_in == CODE_RSHIFT) begin
              shift_d = 1'b1;
            end else if (m[5]) begin
              if (!(SUPPRESS_REPEAT != 0 && scan_code_in == held_q)) begin
                push     = 1'b1;
                push_tok = m[4:0];
                held_d   = scan_code_in;
              end
            end
          end
          ST_EXT: begin
            // Keypad enter is the only extended key that produces a token
            if (scan_code_in == CODE_ENTER) begin
              push     = 1'b1;
              push_tok = '{enter: 1'b1, data: 4'hF};
            end
          end
          ST_BRK: begin
            if (scan_code_in == CODE_LSHIFT || scan_code_in == CODE_RSHIFT) shift_d = 1'b0;
            if (scan_code_in == held_q) held_d = 8'h00;
          end
          default: ;  // extended break: byte discarded
        endcase
      end
    end
  end

  // Decoder state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= 1'b0;
      held_q  <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      shift_q <= shift_d;
      held_q  <= held_d;
    end
  end

  // ---------------- FIFO ----------------
  token_t          mem [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  token_t          last_q;
  logic            empty, full, pop, push_ok, drop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = !empty && kif.key_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  // Level and sticky overflow next-state
  always_comb begin
    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + LW'(1);
    else if (!push_ok && pop) level_d = level_q - LW'(1);
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  // Token storage write port
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an empty FIFO never exposes its contents.
    if (push_ok) mem[wr_q] <= push_tok;
  end

  // FIFO pointers, level, overflow flag and last-popped token
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q   <= rd_q + AW'(1);
        last_q <= mem[rd_q];
      end
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Head falls through; an empty FIFO keeps showing the last popped token
  assign kif.key_valid = !empty;
  assign kif.key_data  = empty ? last_q.data  : mem[rd_q].data;
  assign kif.key_enter = empty ? last_q.enter : mem[rd_q].enter;
  assign fifo_level    = level_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_scan_key_decoder.sv
// Directed bench for scan_key_decoder: single-key decode table plus multi-cycle sequences.
module tb_scan_key_decoder;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    scan_code_in = 8'h00;
  logic          scan_valid = 1'b0;
  logic          clear_ovf = 1'b0;
  logic          ready = 1'b0;
  logic [LW-1:0] level, level_nr;
  logic          ovf, ovf_nr;

  scan_key_decoder_if kif ();
  scan_key_decoder_if kif_nr ();
  assign kif.key_ready    = ready;
  assign kif_nr.key_ready = ready;

  scan_key_decoder #(.DEPTH(DEPTH), .SUPPRESS_REPEAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .scan_code_in(scan_code_in), .scan_valid(scan_valid),
    .kif(kif.master), .fifo_level(level), .overflow(ovf), .clear_ovf(clear_ovf));

  scan_key_decoder #(.DEPTH(DEPTH), .SUPPRESS_REPEAT(0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .scan_code_in(scan_code_in), .scan_valid(scan_valid),
    .kif(kif_nr.master), .fifo_level(level_nr), .overflow(ovf_nr), .clear_ovf(clear_ovf));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [4:0] log_q [$];

  // Record every token popped from the suppressing instance as {enter, data}
  always @(posedge clk)
    if (rst_n && kif.key_valid && kif.key_ready) log_q.push_back({kif.key_enter, kif.key_data});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code_in = b;
    scan_valid   = 1'b1;
    @(negedge clk);
    scan_valid   = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && (level != 0 || level_nr != 0); i++) @(negedge clk);
    ready = 1'b0;
    check("drain_level", 32'(level), 32'd0);
    check("drain_level_nr", 32'(level_nr), 32'd0);
  endtask

  task automatic check_log(input string name, input logic [4:0] exp [$]);
    check({name, "_count"}, 32'(log_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check($sformatf("%s_tok%0d", name, i), 32'(log_q[i]), 32'(exp[i]));
    log_q.delete();
  endtask

  typedef struct {
    logic [7:0] pre;
    logic [7:0] code;
    logic       hit;
    logic [3:0] data;
    logic       enter;
  } vec_t;

  vec_t vecs [19];

  initial begin
    vecs[0]  = '{8'h00, 8'h16, 1'b1, 4'h1, 1'b0};
    vecs[1]  = '{8'h00, 8'h1E, 1'b1, 4'h2, 1'b0};
    vecs[2]  = '{8'h00, 8'h26, 1'b1, 4'h3, 1'b0};
    vecs[3]  = '{8'h00, 8'h25, 1'b1, 4'h4, 1'b0};
    vecs[4]  = '{8'h00, 8'h2E, 1'b1, 4'h5, 1'b0};
    vecs[5]  = '{8'h00, 8'h36, 1'b1, 4'h6, 1'b0};
    vecs[6]  = '{8'h00, 8'h3D, 1'b1, 4'h7, 1'b0};
    vecs[7]  = '{8'h00, 8'h3E, 1'b1, 4'h8, 1'b0};
    vecs[8]  = '{8'h00, 8'h46, 1'b1, 4'h9, 1'b0};
    vecs[9]  = '{8'h00, 8'h45, 1'b1, 4'h0, 1'b0};
    vecs[10] = '{8'h00, 8'h4A, 1'b1, 4'hA, 1'b0};
    vecs[11] = '{8'h00, 8'h4E, 1'b1, 4'hB, 1'b0};
    vecs[12] = '{8'h00, 8'h5D, 1'b1, 4'hC, 1'b0};
    vecs[13] = '{8'h00, 8'h66, 1'b1, 4'hE, 1'b0};
    vecs[14] = '{8'h00, 8'h5A, 1'b1, 4'hF, 1'b1};
    vecs[15] = '{8'h00, 8'h12, 1'b0, 4'h0, 1'b0};
    vecs[16] = '{8'h00, 8'h1C, 1'b0, 4'h0, 1'b0};
    vecs[17] = '{8'hE0, 8'h5A, 1'b1, 4'hF, 1'b1};
    vecs[18] = '{8'hE0, 8'h4A, 1'b0, 4'h0, 1'b0};

    // Reset state
    #12;
    check("rst_valid", 32'(kif.key_valid), 32'd0);
    check("rst_data", 32'(kif.key_data), 32'd0);
    check("rst_enter", 32'(kif.key_enter), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-key decode table: make, inspect head, pop, release
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].pre != 8'h00) send(vecs[i].pre);
      send(vecs[i].code);
      check($sformatf("tbl%0d_valid", i), 32'(kif.key_valid), 32'(vecs[i].hit));
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(vecs[i].hit));
      if (vecs[i].hit) begin
        check($sformatf("tbl%0d_data", i), 32'(kif.key_data), 32'(vecs[i].data));
        check($sformatf("tbl%0d_enter", i), 32'(kif.key_enter), 32'(vecs[i].enter));
        pop_one();
      end
      if (vecs[i].pre != 8'h00) send(vecs[i].pre);
      send(8'hF0);
      send(vecs[i].code);
    end
    drain();
    log_q.delete();

    // 1) make/break of '1' and enter with the consumer always ready
    ready = 1'b1;
    send(8'h16); send(8'hF0); send(8'h16); send(8'h5A); send(8'hF0); send(8'h5A);
    @(negedge clk);
    ready = 1'b0;
    check_log("seq1", '{5'h01, 5'h1F});
    check("seq1_level", 32'(level), 32'd0);
    check("seq1_hold_data", 32'(kif.key_data), 32'hF);
    check("seq1_hold_enter", 32'(kif.key_enter), 32'd1);

    // 2) shifted '5' gives '%', shift released before the second '5'
    ready = 1'b1;
    send(8'h12); send(8'h2E); send(8'hF0); send(8'h2E); send(8'hF0); send(8'h12); send(8'h2E);
    @(negedge clk);
    ready = 1'b0;
    check_log("seq2", '{5'h0D, 5'h05});
    send(8'hF0); send(8'h2E);

    // 3) typematic repeats suppressed on one instance, all pushed on the other
    send(8'h1E); send(8'h1E); send(8'h1E); send(8'hF0); send(8'h1E); send(8'h1E);
    check("seq3_level", 32'(level), 32'd2);
    check("seq3_level_nr", 32'(level_nr), 32'd4);
    check("seq3_head", 32'(kif.key_data), 32'h2);
    drain();
    log_q.delete();
    send(8'hF0); send(8'h1E);

    // 4) extended keys: only keypad enter decodes; FSM returns to IDLE
    send(8'hE0); send(8'h5A);
    check("seq4_enter_level", 32'(level), 32'd1);
    check("seq4_enter_flag", 32'(kif.key_enter), 32'd1);
    send(8'hE0); send(8'h4A); send(8'hE0); send(8'hF0); send(8'h5A);
    check("seq4_ext_discard", 32'(level), 32'd1);
    send(8'h16);
    check("seq4_idle_level", 32'(level), 32'd2);
    drain();
    check_log("seq4", '{5'h1F, 5'h01});
    send(8'hF0); send(8'h16);

    // 5) overflow, push+pop at full, clear_ovf priority
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    send(8'h36); send(8'h3D); send(8'h3E); send(8'h46); send(8'h45);
    check("seq5_full_level", 32'(level), 32'(DEPTH));
    check("seq5_ovf_set", 32'(ovf), 32'd1);
    @(negedge clk);
    scan_code_in = 8'h4A; scan_valid = 1'b1; ready = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; ready = 1'b0;
    check("seq5_pushpop_level", 32'(level), 32'(DEPTH));
    check_log("seq5_pushpop_pop", '{5'h01});
    @(negedge clk); clear_ovf = 1'b1;
    @(negedge clk); clear_ovf = 1'b0;
    check("seq5_ovf_clear", 32'(ovf), 32'd0);
    @(negedge clk);
    scan_code_in = 8'h4E; scan_valid = 1'b1; clear_ovf = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; clear_ovf = 1'b0;
    check("seq5_drop_beats_clear", 32'(ovf), 32'd1);
    check("seq5_drop_level", 32'(level), 32'(DEPTH));
    drain();
    check_log("seq5_order", '{5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h0A});
    @(negedge clk); clear_ovf = 1'b1;
    @(negedge clk); clear_ovf = 1'b0;
    check("seq5_ovf_final", 32'(ovf), 32'd0);

    // 6) reset between F0 and its code
    send(8'h16);
    check("seq6_pre_level", 32'(level), 32'd1);
    send(8'hF0);
    #3 rst_n = 1'b0;
    #1;
    check("seq6_rst_valid", 32'(kif.key_valid), 32'd0);
    check("seq6_rst_data", 32'(kif.key_data), 32'd0);
    check("seq6_rst_enter", 32'(kif.key_enter), 32'd0);
    check("seq6_rst_level", 32'(level), 32'd0);
    check("seq6_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    send(8'h16);
    check("seq6_make_level", 32'(level), 32'd1);
    check("seq6_make_data", 32'(kif.key_data), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
